// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one external registered adder among NUM_REQ lanes.
// Defining ADDER_ARB_STATS_EN adds a saturating handshake counter on stat_grants.
module adder_rr_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_in1,
  output logic [WIDTH-1:0]         add_in2,
  input  logic [WIDTH:0]           add_out,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH:0]           rsp_sum,
  output logic                     idle,
  output logic [15:0]              stat_grants
);
  // state | meaning
  // IDLE  | no grants; leaves for RUN once en=1 is sampled
  // RUN   | round-robin grants while en=1; en=0 moves to DRAIN
  // DRAIN | no grants; returns to IDLE once no tag is in flight

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] ptr;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W:0]   scan;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [LATENCY-1:0] tag_vld;
  logic [IDX_W-1:0]   tag_idx [LATENCY];
  logic             pipe_empty;

  assign pipe_empty = ~|tag_vld;

  // Scan upward from the pointer with wrap; the first valid lane wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    req_ready = '0;
    if (state == RUN && en && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan = {1'b0, ptr} + (IDX_W+1)'(k);
        if (scan >= (IDX_W+1)'(NUM_REQ))
          scan = scan - (IDX_W+1)'(NUM_REQ);
        if (!grant_any && req_valid[scan[IDX_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = scan[IDX_W-1:0];
        end
      end
      if (grant_any)
        req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = DRAIN;
      DRAIN:   if (pipe_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idle      <= 1'b1;
      ptr       <= '0;
      add_in1   <= '0;
      add_in2   <= '0;
      tag_vld   <= '0;
      rsp_valid <= '0;
    end else begin
      state <= state_next;
      idle  <= (state_next == IDLE);
      if (grant_any) begin
        ptr     <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        add_in1 <= sel_a;
        add_in2 <= sel_b;
      end
      tag_vld[0] <= grant_any;
      for (int k = 1; k < LATENCY; k++)
        tag_vld[k] <= tag_vld[k-1];
      rsp_valid <= '0;
      if (tag_vld[LATENCY-1])
        rsp_valid[tag_idx[LATENCY-1]] <= 1'b1;
    end
  end

  // Tag indices are only meaningful alongside tag_vld, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_idx[0] <= grant_idx;
    for (int k = 1; k < LATENCY; k++)
      tag_idx[k] <= tag_idx[k-1];
  end

  assign rsp_sum = (|rsp_valid) ? add_out : '0;

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] grant_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      grant_cnt <= '0;
    else if (grant_any && grant_cnt != 16'hFFFF)
      grant_cnt <= grant_cnt + 16'd1;
  end

  assign stat_grants = grant_cnt;
`else
  assign stat_grants = 16'h0000;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomised plus directed bench for adder_rr_arbiter against a queue-based reference model.
// An external LATENCY-stage adder is modelled here to close the datapath loop.
module tb_adder_rr_arbiter;
  localparam int W = 4;
  localparam int N = 4;
  localparam int L = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic           clk;
  logic           rst;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   add_in1;
  logic [W-1:0]   add_in2;
  logic [W:0]     add_out;
  logic [N-1:0]   rsp_valid;
  logic [W:0]     rsp_sum;
  logic           idle;
  logic [15:0]    stat_grants;

  adder_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
    .idle(idle), .stat_grants(stat_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder: L register stages from operands to sum, reset with the arbiter.
  logic [W:0] apipe [L];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < L; k++) apipe[k] <= '0;
    end else begin
      apipe[0] <= {1'b0, add_in1} + {1'b0, add_in2};
      for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
    end
  end
  assign add_out = apipe[L-1];

  typedef struct {
    int due;
    int lane;
    int sum;
  } rsp_t;

  rsp_t exp_q[$];
  int   m_state;
  int   m_ptr;
  int   m_in1;
  int   m_in2;
  int   m_stat;
  bit   m_prev_rst;
  int   cyc;
  int   checks;
  int   failures;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state    = M_IDLE;
    m_ptr      = 0;
    m_in1      = 0;
    m_in2      = 0;
    m_stat     = 0;
    m_prev_rst = 1'b1;
  endtask

  // One clock cycle: drive, sample at negedge, compare, advance the model.
  task automatic cycle(input bit r, input bit e, input logic [N-1:0] v,
                       input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    int   eg;
    int   ai;
    int   bi;
    bit   empty;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    int   exp_sum;
    rsp_t ent;
    rst = r; en = e; req_valid = v; req_a = a; req_b = b;
    @(negedge clk);
    eg = -1;
    if (!r && e && m_state == M_RUN) begin
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr + k) % N;
        if (eg < 0 && v[i]) eg = i;
      end
    end
    exp_ready = '0;
    if (eg >= 0) exp_ready[eg] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    exp_rv  = '0;
    exp_sum = 0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rv[exp_q[0].lane] = 1'b1;
      exp_sum = exp_q[0].sum;
      void'(exp_q.pop_front());
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv != '0) chk("rsp_sum", 32'(rsp_sum), 32'(exp_sum));
    else if (m_prev_rst) chk("rsp_sum_rst", 32'(rsp_sum), 32'd0);
    chk("idle", 32'(idle), 32'(m_state == M_IDLE));
    chk("add_in1", 32'(add_in1), 32'(m_in1));
    chk("add_in2", 32'(add_in2), 32'(m_in2));
    chk("stat_grants", 32'(stat_grants), 32'(m_stat));
    empty = (exp_q.size() == 0);
    if (r) begin
      model_reset();
    end else begin
      m_prev_rst = 1'b0;
      if (eg >= 0) begin
        ai = int'(a[eg*W +: W]);
        bi = int'(b[eg*W +: W]);
        m_ptr = (eg + 1) % N;
        m_in1 = ai;
        m_in2 = bi;
        ent.due  = cyc + L + 1;
        ent.lane = eg;
        ent.sum  = ai + bi;
        exp_q.push_back(ent);
`ifdef ADDER_ARB_STATS_EN
        if (m_stat < 16'hFFFF) m_stat++;
`endif
      end
      case (m_state)
        M_IDLE:  if (e) m_state = M_RUN;
        M_RUN:   if (!e) m_state = M_DRAIN;
        default: if (empty) m_state = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet(input bit e, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, e, '0, '0, '0);
  endtask

  logic [N*W-1:0] ra, rb;
  logic [N-1:0]   rv;
  bit             ren;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle(1'b1, 1'b0, '0, '0, '0);
    quiet(1'b0, 2);

    // Single op: lane0 F+1
    quiet(1'b1, 1);
    cycle(1'b0, 1'b1, 4'b0001, 16'h000F, 16'h0001);
    quiet(1'b1, L + 2);

    // All lanes continuously valid from pointer 0
    cycle(1'b1, 1'b0, '0, '0, '0);
    quiet(1'b1, 1);
    for (int k = 0; k < 6; k++)
      cycle(1'b0, 1'b1, 4'b1111, {4'd3, 4'd2, 4'd1, 4'd0}, {4'd3, 4'd2, 4'd1, 4'd0});
    quiet(1'b1, L + 2);

    // Drain after three back-to-back issues, en toggling inside DRAIN
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 1'b1, 4'b0001, 16'h0007, 16'h0009);
    cycle(1'b0, 1'b0, 4'b0001, 16'h0007, 16'h0009);
    cycle(1'b0, 1'b1, 4'b0001, 16'h0007, 16'h0009);
    quiet(1'b0, 6);

    // Reset one cycle after a handshake
    quiet(1'b1, 1);
    cycle(1'b0, 1'b1, 4'b0100, 16'h0500, 16'h0300);
    cycle(1'b1, 1'b1, 4'b0100, 16'h0500, 16'h0300);
    quiet(1'b0, 5);

    // Fairness: pointer parked at 2, lanes 1 and 3 contend
    quiet(1'b1, 1);
    cycle(1'b0, 1'b1, 4'b0010, 16'h0020, 16'h0010);
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 1'b1, 4'b1010, 16'hA0B0, 16'h1234);
    quiet(1'b1, L + 2);

    // Five handshakes then reset: stats follow
    for (int k = 0; k < 5; k++)
      cycle(1'b0, 1'b1, 4'b1000, 16'h8000, 16'h8000);
    quiet(1'b1, 2);
    cycle(1'b1, 1'b1, '0, '0, '0);
    quiet(1'b0, 2);

    // Random traffic with en runs and rare resets
    ren = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) ren = ~ren;
      rv = N'($urandom);
      ra = (N*W)'($urandom);
      rb = (N*W)'($urandom);
      cycle($urandom_range(0, 99) == 0, ren, rv, ra, rb);
    end
    quiet(1'b0, L + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
